// File: rtl/note_fetch_arbiter.sv
// Purpose: round-robin chart fetcher that serves per-lane note requests from one shared chart memory.
// Latency: note_time updates MEM_LAT+1 edges after the edge that samples lane_req (idle arbiter).
// Backpressure: none upstream; requests coalesce into one pending flag per lane, one fetch per MEM_LAT+1 clocks.
module note_fetch_arbiter #(
  parameter int NUM_LANES = 5,
  parameter int PTR_W     = 9,
  parameter int MEM_LAT   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_LANES-1:0]      lane_req,
  output logic [3+PTR_W-1:0]        mem_addr,
  input  logic [17:0]               mem_data,
  output logic [18*NUM_LANES-1:0]   note_time,
  output logic [NUM_LANES-1:0]      note_load,
  output logic                      busy,
  output logic                      done
);

  localparam int              CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [17:0]     TERM    = 18'h3FFFF;
  localparam logic [PTR_W-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_FETCH} state_t;

  state_t                  r_state;
  logic [NUM_LANES-1:0]    r_pend;
  logic [NUM_LANES-1:0]    r_exh;
  logic [PTR_W-1:0]        r_ptr [NUM_LANES];
  logic [2:0]              r_rr;
  logic [2:0]              r_lane;
  logic [CNT_W-1:0]        r_cnt;
  logic [3+PTR_W-1:0]      r_mem_addr;
  logic [18*NUM_LANES-1:0] r_note_time;
  logic [NUM_LANES-1:0]    r_note_load;

  logic                    w_gnt_vld;
  logic [2:0]              w_gnt_lane;
  logic [3:0]              w_idx;
  logic                    w_last;
  logic                    w_exh_now;
  logic [NUM_LANES-1:0]    w_gnt_clr;
  logic [NUM_LANES-1:0]    w_exh_set;
  logic [NUM_LANES-1:0]    w_pend_next;

  // Cyclic search for the first pending lane at or after the round-robin pointer.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_lane = '0;
    w_idx      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_idx = {1'b0, r_rr} + 4'(i);
      if (w_idx >= 4'(NUM_LANES)) w_idx = w_idx - 4'(NUM_LANES);
      if (!w_gnt_vld && r_pend[w_idx[2:0]]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_lane = w_idx[2:0];
      end
    end
  end

  // Pending update: a new request wins over the grant clear, so a re-request is never lost;
  // a lane that exhausts on this edge drops any request it collected during its fetch.
  always_comb begin
    w_last      = (r_state == S_FETCH) && (r_cnt == CNT_W'(MEM_LAT - 1));
    w_exh_now   = w_last && ((mem_data == TERM) || (r_ptr[r_lane] == PTR_MAX));
    w_gnt_clr   = (r_state == S_ARB && w_gnt_vld) ? (NUM_LANES'(1) << w_gnt_lane) : '0;
    w_exh_set   = w_exh_now ? (NUM_LANES'(1) << r_lane) : '0;
    w_pend_next = ((r_pend & ~w_gnt_clr) | lane_req) & ~r_exh & ~w_exh_set;
  end

  // Arbiter FSM: start re-primes from any state, ARB grants, FETCH waits out the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_exh       <= '0;
      r_rr        <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_note_time <= '1;
      r_note_load <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_ptr[i] <= '0;
    end else if (start) begin
      r_state     <= S_ARB;
      r_pend      <= '1;
      r_exh       <= '0;
      r_rr        <= '0;
      r_cnt       <= '0;
      r_note_time <= '1;
      r_note_load <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_ptr[i] <= '0;
    end else begin
      r_note_load <= '0;
      if (r_state != S_IDLE) r_pend <= w_pend_next;
      case (r_state)
        S_ARB: begin
          if (w_gnt_vld) begin
            r_mem_addr <= {w_gnt_lane, r_ptr[w_gnt_lane]};
            r_lane     <= w_gnt_lane;
            r_rr       <= (w_gnt_lane == 3'(NUM_LANES - 1)) ? 3'd0 : w_gnt_lane + 3'd1;
            r_cnt      <= '0;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_last) begin
            r_note_time[18*int'(r_lane) +: 18] <= mem_data;
            r_note_load[r_lane]                <= 1'b1;
            // Terminator or last chart slot: lane is finished, pointer parks where it is.
            if (w_exh_now) r_exh[r_lane] <= 1'b1;
            else           r_ptr[r_lane] <= r_ptr[r_lane] + PTR_W'(1);
            r_state <= S_ARB;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign note_time = r_note_time;
  assign note_load = r_note_load;
  assign busy      = (|r_pend) || (r_state == S_FETCH);
  assign done      = (&r_exh) && (r_state != S_IDLE);

endmodule

// File: tb/tb_note_fetch_arbiter.sv
// Bench for note_fetch_arbiter: chart memory model, fetch scoreboard, per-scenario tasks.
// Expected fetches come from a pointer/exhausted model of each lane and are queued at stimulus time.
// Observed note_load events are collected by a monitor and compared in order, including load cycle.
module tb_note_fetch_arbiter;

  localparam int N     = 5;
  localparam int PTR_W = 9;
  localparam int DEPTH = 1 << PTR_W;
  localparam logic [17:0] TERM = 18'h3FFFF;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic [N-1:0]        lane_req = '0;
  logic [3+PTR_W-1:0]  mem_addr;
  logic [17:0]         mem_data;
  logic [18*N-1:0]     note_time;
  logic [N-1:0]        note_load;
  logic                busy;
  logic                done;

  note_fetch_arbiter #(.NUM_LANES(N), .PTR_W(PTR_W), .MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lane_req(lane_req),
    .mem_addr(mem_addr), .mem_data(mem_data), .note_time(note_time),
    .note_load(note_load), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int lane; logic [17:0] val; int cyc; } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  ev_t         mon_ev;
  ev_t         e;
  ev_t         o;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [17:0] chart [N][DEPTH];
  logic [17:0] mem_q;
  int          m_ptr [N];
  bit          m_exh [N];

  // Chart memory: the DUT's registered mem_addr is the first latency stage, this register the second.
  always @(posedge clk) begin
    if (int'(mem_addr[PTR_W+2:PTR_W]) < N) mem_q <= chart[int'(mem_addr[PTR_W+2:PTR_W])][int'(mem_addr[PTR_W-1:0])];
    else mem_q <= 18'h0;
  end
  assign mem_data = mem_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every note_load event with the lane, loaded value and edge number.
  always @(posedge clk) begin
    #1;
    if (note_load !== '0) begin
      mon_ev.lane = -1;
      for (int i = 0; i < N; i++)
        if (note_load[i]) mon_ev.lane = (mon_ev.lane == -1) ? i : 99;
      mon_ev.val = (mon_ev.lane >= 0 && mon_ev.lane < N) ? note_time[18*mon_ev.lane +: 18] : 18'h0;
      mon_ev.cyc = cyc;
      obs_q.push_back(mon_ev);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    lane_req = m;
    tick(1);
    lane_req = '0;
  endtask

  // Reference model of one fetch of lane l; queues the expected load.
  task automatic exp_fetch(input int l, input int at_cyc);
    ev_t x;
    x.lane = l;
    x.val  = chart[l][m_ptr[l]];
    x.cyc  = at_cyc;
    exp_q.push_back(x);
    if (x.val == TERM || m_ptr[l] == DEPTH - 1) m_exh[l] = 1'b1;
    else m_ptr[l] = m_ptr[l] + 1;
  endtask

  // Start: all lanes re-primed and fetched in lane order, first load 3 edges after start is sampled.
  task automatic do_start();
    int k;
    k = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int l = 0; l < N; l++) begin m_ptr[l] = 0; m_exh[l] = 1'b0; end
    for (int l = 0; l < N; l++) exp_fetch(l, k + 4 + 3 * l);
  endtask

  task automatic wait_obs(input int n, input int budget, input string nm);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin tick(1); c++; end
    tests++;
    if (obs_q.size() < n) begin
      fails++;
      $display("FAIL %s timeout: got %0d loads, want %0d", nm, obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    tests++; if (mem_addr !== '0) begin fails++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    tests++; if (note_time !== {N{TERM}}) begin fails++; $display("FAIL reset note_time: got %h want all ones", note_time); end
    tests++; if (note_load !== '0) begin fails++; $display("FAIL reset note_load: got %b want 0", note_load); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset done: got %b want 0", done); end
    tick(2);
    rst_n = 1'b1;
    tick(1);
    pulse_req('1);
    tick(8);
    tests++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL idle_req: got %0d loads busy %b, want 0 loads busy 0", obs_q.size(), busy);
    end
    obs_q.delete();
  endtask

  task automatic test_prime(input string nm);
    do_start();
    wait_obs(N, 40, nm);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.lane !== e.lane || o.val !== e.val || o.cyc !== e.cyc) begin
        fails++; $display("FAIL %s: got lane %0d val %0d cyc %0d, want lane %0d val %0d cyc %0d",
                          nm, o.lane, o.val, o.cyc, e.lane, e.val, e.cyc);
      end
    end
    tests++;
    if (note_time !== {18'd500, 18'd400, 18'd300, 18'd200, 18'd100} || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL %s final: got note_time %h busy %b done %b, want 500..100 busy 0 done 0", nm, note_time, busy, done);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single();
    int k;
    chart[2][1] = 18'd350;
    k = cyc;
    pulse_req(5'b00100);
    exp_fetch(2, k + 4);
    wait_obs(1, 20, "single");
    tick(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.lane !== e.lane || o.val !== e.val || o.cyc !== e.cyc) begin
        fails++; $display("FAIL single: got lane %0d val %0d cyc %0d, want lane %0d val %0d cyc %0d",
                          o.lane, o.val, o.cyc, e.lane, e.val, e.cyc);
      end
    end
    tests++;
    if (obs_q.size() != 0 || note_load !== '0) begin
      fails++; $display("FAIL single_pulse: got %0d extra loads note_load %b, want 0", obs_q.size(), note_load);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // Round-robin pointer sits at 3 after lane 2 was served.
  task automatic test_contention();
    int k;
    chart[3][1] = 18'd403; chart[4][1] = 18'd504; chart[0][1] = 18'd101; chart[1][1] = 18'd201;
    k = cyc;
    pulse_req(5'b11011);
    exp_fetch(3, k + 4); exp_fetch(4, k + 7); exp_fetch(0, k + 10); exp_fetch(1, k + 13);
    wait_obs(4, 40, "contention");
    tick(8);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.lane !== e.lane || o.val !== e.val || o.cyc !== e.cyc) begin
        fails++; $display("FAIL contention: got lane %0d val %0d cyc %0d, want lane %0d val %0d cyc %0d",
                          o.lane, o.val, o.cyc, e.lane, e.val, e.cyc);
      end
    end
    tests++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL contention_once: got %0d extra loads busy %b, want 0 busy 0", obs_q.size(), busy);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // lane_req[0] held over the request edge, the grant edge and the first FETCH edge.
  task automatic test_rerequest();
    int k;
    chart[0][2] = 18'd102;
    k = cyc;
    lane_req = 5'b00001;
    tick(3);
    lane_req = '0;
    exp_fetch(0, k + 4); exp_fetch(0, k + 7);
    wait_obs(2, 30, "rerequest");
    tick(6);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.lane !== e.lane || o.val !== e.val || o.cyc !== e.cyc) begin
        fails++; $display("FAIL rerequest: got lane %0d val %0d cyc %0d, want lane %0d val %0d cyc %0d",
                          o.lane, o.val, o.cyc, e.lane, e.val, e.cyc);
      end
    end
    tests++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL rerequest_count: got %0d extra loads, want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_terminator_done();
    int k;
    bit busy_seen;
    chart[1][1] = TERM;
    k = cyc;
    pulse_req(5'b00010);
    exp_fetch(1, k + 4);
    wait_obs(1, 20, "term");
    tests++;
    if (mem_addr !== {3'd1, 9'd1}) begin fails++; $display("FAIL term_addr: got %h want %h", mem_addr, {3'd1, 9'd1}); end
    busy_seen = 1'b0;
    lane_req = 5'b00010;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      lane_req = '0;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    tests++;
    if (busy_seen || obs_q.size() != 1) begin
      fails++; $display("FAIL term_ignore: got busy_seen %b loads %0d, want 0 and 1", busy_seen, obs_q.size());
    end
    // Remaining lanes run into terminators: lane 0 at entry 3, lanes 2..4 at entry 2.
    k = cyc;
    pulse_req(5'b11101);
    exp_fetch(2, k + 4); exp_fetch(3, k + 7); exp_fetch(4, k + 10); exp_fetch(0, k + 13);
    wait_obs(5, 40, "done_round1");
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_early: got %b want 0", done); end
    k = cyc;
    pulse_req(5'b11100);
    exp_fetch(2, k + 4); exp_fetch(3, k + 7); exp_fetch(4, k + 10);
    wait_obs(8, 40, "done_round2");
    tick(2);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
      if (o.lane !== e.lane || o.val !== e.val || o.cyc !== e.cyc) begin
        fails++; $display("FAIL term_seq: got lane %0d val %h cyc %0d, want lane %0d val %h cyc %0d",
                          o.lane, o.val, o.cyc, e.lane, e.val, e.cyc);
      end
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL done: got done %b busy %b, want 1 0", done, busy); end
    exp_q.delete(); obs_q.delete();
  endtask

  // Lane 4 walks its whole chart; the last slot holds a real note and still ends the lane.
  task automatic test_ptr_end();
    int k;
    int errs = 0;
    bit busy_seen = 1'b0;
    for (int j = 1; j < DEPTH; j++) chart[4][j] = 18'(j + 7);
    do_start();
    wait_obs(N, 40, "ptr_prime");
    exp_q.delete(); obs_q.delete();
    for (int j = 1; j < DEPTH; j++) begin
      k = cyc;
      pulse_req(5'b10000);
      exp_fetch(4, k + 4);
      wait_obs(1, 10, "ptr_walk");
      if (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); tests++;
        if (o.lane !== e.lane || o.val !== e.val || o.cyc !== e.cyc) begin
          fails++; errs++;
          if (errs < 5) $display("FAIL ptr_walk[%0d]: got lane %0d val %0d cyc %0d, want lane %0d val %0d cyc %0d",
                                 j, o.lane, o.val, o.cyc, e.lane, e.val, e.cyc);
        end
      end
    end
    lane_req = 5'b10000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      lane_req = '0;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    tests++;
    if (busy_seen || obs_q.size() != 0 || note_time[4*18 +: 18] !== 18'd518) begin
      fails++; $display("FAIL ptr_end: got busy_seen %b loads %0d lane4 %0d, want 0 0 518",
                        busy_seen, obs_q.size(), note_time[4*18 +: 18]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_async_reset();
    do_start();
    wait_obs(N, 40, "arst_prime");
    exp_q.delete(); obs_q.delete();
    pulse_req(5'b00100);
    tick(1);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL arst_inflight: got busy %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (mem_addr !== '0) begin fails++; $display("FAIL arst mem_addr: got %h want 0", mem_addr); end
    tests++; if (note_time !== {N{TERM}}) begin fails++; $display("FAIL arst note_time: got %h want all ones", note_time); end
    tests++;
    if (note_load !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL arst ctrl: got load %b busy %b done %b, want 0 0 0", note_load, busy, done);
    end
    #3 rst_n = 1'b1;
    tick(1);
    pulse_req('1);
    tick(12);
    tests++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL arst_no_load: got %0d loads busy %b, want 0 0", obs_q.size(), busy);
    end
    obs_q.delete();
    do_start();
    wait_obs(N, 40, "arst_restart");
    tests++;
    if (note_time !== {18'd500, 18'd400, 18'd300, 18'd200, 18'd100}) begin
      fails++; $display("FAIL arst_restart: got %h want 500..100", note_time);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int l = 0; l < N; l++)
      for (int j = 0; j < DEPTH; j++) chart[l][j] = TERM;
    for (int l = 0; l < N; l++) chart[l][0] = 18'(100 * (l + 1));
    for (int l = 0; l < N; l++) begin m_ptr[l] = 0; m_exh[l] = 1'b0; end
    test_reset();
    test_prime("prime");
    test_single();
    test_contention();
    test_prime("reprime");
    test_rerequest();
    test_terminator_done();
    test_ptr_end();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
